ibex_obi_tl_bridge: RTL

- Converts the Ibex core data-memory request/grant/rvalid interface into a TileLink-UL-style decoupled A/D channel pair.
- Sits directly downstream of the core wrapper's data port and upstream of the SoC memory fabric.
- Supports multiple outstanding transactions. Fabric responses may arrive out of order; they are reordered by source ID and returned to the core strictly in issue order, as the core protocol requires.

---
 rtl/ibex_tl_pkg.sv | 18 +
 rtl/ibex_tl_rob.sv | 100 ++++++++++
 rtl/ibex_obi_tl_bridge.sv | 62 ++++++
 3 files changed

// File: rtl/ibex_tl_pkg.sv
// ibex_tl_pkg: shared TileLink-UL types and helpers for the Ibex data-port bridge
package ibex_tl_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } tl_a_op_e;
  typedef struct packed {
    logic        inflight;
    logic        resp_valid;
    logic        err;
    logic [31:0] data;
  } rob_entry_t;
  localparam logic [1:0] TL_SIZE_WORD = 2'd2;
  function automatic tl_a_op_e tl_opcode(input logic we, input logic [3:0] be);
    return !we ? Get : (be == 4'hF) ? PutFullData : PutPartialData;
  endfunction
endpackage

// File: rtl/ibex_tl_rob.sv
// ibex_tl_rob: reorder buffer returning out-of-order D responses to the core in issue order
module ibex_tl_rob
  import ibex_tl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  localparam int SRC_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic             i_push_put,
  output logic             o_slot_free,
  output logic [SRC_W-1:0] o_tail,
  output logic             o_busy,
  input  logic             i_d_valid,
  input  logic [SRC_W-1:0] i_d_source,
  input  logic [31:0]      i_d_data,
  input  logic             i_d_err,
  output logic             o_rvalid,
  output logic [31:0]      o_rdata,
  output logic             o_err,
  output logic             o_proto_err
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SRC_W:0] MAX_S = (SRC_W + 1)'(MAX_OUTSTANDING);
  rob_entry_t r_rob [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_put;
  logic [SRC_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic r_rvalid, r_err, r_proto_err;
  logic [31:0] r_rdata;
  logic w_src_ok, w_d_ok, w_bypass, w_retire, w_ret_err;
  logic [31:0] w_d_data, w_ret_data;
  rob_entry_t w_d_ent, w_head_ent;
  function automatic logic [SRC_W-1:0] nxt(input logic [SRC_W-1:0] x);
    return (x == SRC_W'(MAX_OUTSTANDING - 1)) ? '0 : x + SRC_W'(1);
  endfunction
  // Accept a D beat only for an in-flight, not-yet-answered source; bypass straight to retire when it is the head
  always_comb begin
    w_src_ok   = {1'b0, i_d_source} < MAX_S;
    w_d_ent    = w_src_ok ? r_rob[i_d_source] : '0;
    w_head_ent = r_rob[r_head];
    w_d_ok     = i_d_valid & w_src_ok & w_d_ent.inflight & ~w_d_ent.resp_valid;
    w_d_data   = r_put[i_d_source] ? '0 : i_d_data;
    w_bypass   = w_d_ok & (i_d_source == r_head);
    w_retire   = w_head_ent.resp_valid | w_bypass;
    w_ret_data = w_head_ent.resp_valid ? w_head_ent.data : w_d_data;
    w_ret_err  = w_head_ent.resp_valid ? w_head_ent.err : i_d_err;
  end
  // Entry array: allocate on grant, fill on a parked response, clear on retire
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_rob[i] <= '0;
      r_put <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (i_push && SRC_W'(i) == r_tail) begin
          r_rob[i] <= '{1'b1, 1'b0, 1'b0, 32'h0};
          r_put[i] <= i_push_put;
        end else if (w_retire && SRC_W'(i) == r_head) begin
          r_rob[i] <= '0;
        end else if (w_d_ok && !w_bypass && SRC_W'(i) == i_d_source) begin
          r_rob[i].resp_valid <= 1'b1;
          r_rob[i].err        <= i_d_err;
          r_rob[i].data       <= w_d_data;
        end
      end
    end
  end
  // Pointers, occupancy, registered core response and sticky protocol error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (i_push) r_tail <= nxt(r_tail);
      if (w_retire) begin
        r_head  <= nxt(r_head);
        r_rdata <= w_ret_data;
        r_err   <= w_ret_err;
      end
      r_rvalid <= w_retire;
      r_count  <= r_count + CNT_W'(i_push) - CNT_W'(w_retire);
      if (i_d_valid && !w_d_ok) r_proto_err <= 1'b1;
    end
  end
  assign o_slot_free = r_count < MAX_C;
  assign o_busy      = r_count != '0;
  assign o_tail      = r_tail;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign o_proto_err = r_proto_err;
endmodule

// File: rtl/ibex_obi_tl_bridge.sv
// ibex_obi_tl_bridge: Ibex data req/gnt/rvalid port to TileLink-UL A/D channels
module ibex_obi_tl_bridge
  import ibex_tl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  localparam int SRC_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic             a_valid_o,
  input  logic             a_ready_i,
  output logic [2:0]       a_opcode_o,
  output logic [1:0]       a_size_o,
  output logic [SRC_W-1:0] a_source_o,
  output logic [31:0]      a_address_o,
  output logic [3:0]       a_mask_o,
  output logic [31:0]      a_data_o,
  input  logic             d_valid_i,
  output logic             d_ready_o,
  input  logic [SRC_W-1:0] d_source_i,
  input  logic [31:0]      d_data_i,
  input  logic             d_denied_i,
  input  logic             d_corrupt_i,
  output logic             busy_o,
  output logic             proto_err_o
);
  logic w_slot_free;
  assign a_valid_o   = data_req_i & w_slot_free;
  assign data_gnt_o  = a_valid_o & a_ready_i;
  assign a_opcode_o  = tl_opcode(data_we_i, data_be_i);
  assign a_size_o    = TL_SIZE_WORD;
  assign a_address_o = data_addr_i & 32'hFFFF_FFFC;
  assign a_mask_o    = data_we_i ? data_be_i : 4'hF;
  assign a_data_o    = data_wdata_i;
  assign d_ready_o   = 1'b1;
  ibex_tl_rob #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rob (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_push     (data_gnt_o),
    .i_push_put (data_we_i),
    .o_slot_free(w_slot_free),
    .o_tail     (a_source_o),
    .o_busy     (busy_o),
    .i_d_valid  (d_valid_i),
    .i_d_source (d_source_i),
    .i_d_data   (d_data_i),
    .i_d_err    (d_denied_i | d_corrupt_i),
    .o_rvalid   (data_rvalid_o),
    .o_rdata    (data_rdata_o),
    .o_err      (data_err_o),
    .o_proto_err(proto_err_o)
  );
endmodule
